// File: rtl/y86_pred_decode_execute_if.sv
// Bundled pipeline-control, decode, writeback and M-register signals for the Y86-64 F/D/E core slice.
interface y86_pred_decode_execute_if;
  logic        F_stall_i, F_bubble_i;
  logic        E_stall_i, E_bubble_i;
  logic        M_stall_i, M_bubble_i;
  logic [63:0] f_predPC_i;
  logic [63:0] F_predPC_o;
  logic [2:0]  d_stat_i;
  logic [3:0]  d_icode_i, d_ifun_i, d_rA_i, d_rB_i;
  logic [63:0] d_valC_i, d_valP_i;
  logic [3:0]  W_dstE_i, W_dstM_i;
  logic [63:0] W_valE_i, W_valM_i;
  logic [2:0]  M_stat_o;
  logic [3:0]  M_icode_o;
  logic        M_cnd_o;
  logic [63:0] M_valE_o, M_valA_o;
  logic [3:0]  M_dstE_o, M_dstM_o;
  logic [2:0]  cc_o;

  modport master (
    output F_stall_i, F_bubble_i, E_stall_i, E_bubble_i, M_stall_i, M_bubble_i,
    output f_predPC_i, d_stat_i, d_icode_i, d_ifun_i, d_rA_i, d_rB_i, d_valC_i, d_valP_i,
    output W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
    input  F_predPC_o, M_stat_o, M_icode_o, M_cnd_o, M_valE_o, M_valA_o, M_dstE_o, M_dstM_o, cc_o
  );

  modport slave (
    input  F_stall_i, F_bubble_i, E_stall_i, E_bubble_i, M_stall_i, M_bubble_i,
    input  f_predPC_i, d_stat_i, d_icode_i, d_ifun_i, d_rA_i, d_rB_i, d_valC_i, d_valP_i,
    input  W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
    output F_predPC_o, M_stat_o, M_icode_o, M_cnd_o, M_valE_o, M_valA_o, M_dstE_o, M_dstM_o, cc_o
  );
endinterface

// File: rtl/y86_pred_decode_execute.sv
// Y86-64 core slice: predicted-PC register, decode with register file, execute with ALU/CC/cnd, M register.
// Optional macro WB_BYPASS_EN: same-cycle writeback data is forwarded to decode reads.
module y86_pred_decode_execute #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic clk_i,
  input logic rst_i,
  y86_pred_decode_execute_if.slave bus
);
  localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4,
                         I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                         I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] R_RSP = 4'h4, R_NONE = 4'hF;
  localparam logic [2:0] S_AOK = 3'h1;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] val_c, val_a, val_b;
    logic [3:0]  dst_e, dst_m;
  } e_reg_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e, val_a;
    logic [3:0]  dst_e, dst_m;
  } m_reg_t;

  localparam e_reg_t E_NOP = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0, val_c: 64'h0,
                               val_a: 64'h0, val_b: 64'h0, dst_e: R_NONE, dst_m: R_NONE};
  localparam m_reg_t M_NOP = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0, val_e: 64'h0,
                               val_a: 64'h0, dst_e: R_NONE, dst_m: R_NONE};

  logic [63:0] f_pred_pc;
  logic [63:0] rf [0:14];
  e_reg_t      e_q, e_d;
  m_reg_t      m_q, m_d;
  logic [2:0]  cc;
  logic [3:0]  src_a, src_b;
  logic [63:0] rd_a, rd_b;
  logic [63:0] alu_a, alu_b, val_e;
  logic [3:0]  alu_fn;
  logic        of_n, cnd, set_cc;

  always_ff @(posedge clk_i) begin
    if (rst_i)                f_pred_pc <= RESET_PC;
    else if (bus.F_stall_i)   f_pred_pc <= f_pred_pc;
    else if (bus.F_bubble_i)  f_pred_pc <= RESET_PC;
    else                      f_pred_pc <= bus.f_predPC_i;
  end

  // dstM is written after dstE so it wins when both target the same register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 15; i++) rf[i] <= 64'h0;
    end else begin
      if (bus.W_dstE_i != R_NONE) rf[bus.W_dstE_i] <= bus.W_valE_i;
      if (bus.W_dstM_i != R_NONE) rf[bus.W_dstM_i] <= bus.W_valM_i;
    end
  end

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    e_d   = E_NOP;
    case (bus.d_icode_i)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.d_rA_i;
      I_RET, I_POPQ:                      src_a = R_RSP;
      default: ;
    endcase
    case (bus.d_icode_i)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:           src_b = bus.d_rB_i;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:      src_b = R_RSP;
      default: ;
    endcase
    rd_a = (src_a == R_NONE) ? 64'h0 : rf[src_a];
    rd_b = (src_b == R_NONE) ? 64'h0 : rf[src_b];
`ifdef WB_BYPASS_EN
    if (src_a != R_NONE) begin
      if (src_a == bus.W_dstM_i)      rd_a = bus.W_valM_i;
      else if (src_a == bus.W_dstE_i) rd_a = bus.W_valE_i;
    end
    if (src_b != R_NONE) begin
      if (src_b == bus.W_dstM_i)      rd_b = bus.W_valM_i;
      else if (src_b == bus.W_dstE_i) rd_b = bus.W_valE_i;
    end
`endif
    e_d.stat  = bus.d_stat_i;
    e_d.icode = bus.d_icode_i;
    e_d.ifun  = bus.d_ifun_i;
    e_d.val_c = bus.d_valC_i;
    e_d.val_a = (bus.d_icode_i == I_JXX || bus.d_icode_i == I_CALL) ? bus.d_valP_i : rd_a;
    e_d.val_b = rd_b;
    case (bus.d_icode_i)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          e_d.dst_e = bus.d_rB_i;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     e_d.dst_e = R_RSP;
      default: ;
    endcase
    if (bus.d_icode_i == I_MRMOVQ || bus.d_icode_i == I_POPQ) e_d.dst_m = bus.d_rA_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)               e_q <= E_NOP;
    else if (bus.E_stall_i)  e_q <= e_q;
    else if (bus.E_bubble_i) e_q <= E_NOP;
    else                     e_q <= e_d;
  end

  always_comb begin
    alu_a = 64'h0;
    alu_b = 64'h0;
    case (e_q.icode)
      I_RRMOVQ, I_OPQ:              alu_a = e_q.val_a;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.val_c;
      I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:                alu_a = 64'h8;
      default: ;
    endcase
    case (e_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_q.val_b;
      default: ;
    endcase
    alu_fn = (e_q.icode == I_OPQ) ? e_q.ifun : 4'h0;
    case (alu_fn)
      4'h1: begin
        val_e = alu_b - alu_a;
        of_n  = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_b[63]);
      end
      4'h2: begin val_e = alu_a & alu_b; of_n = 1'b0; end
      4'h3: begin val_e = alu_a ^ alu_b; of_n = 1'b0; end
      default: begin
        val_e = alu_a + alu_b;
        of_n  = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
      end
    endcase
    // cc = {ZF,SF,OF}; condition evaluated against the flags before this instruction's update
    case (e_q.ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cnd = cc[1] ^ cc[0];
      4'h3:    cnd = cc[2];
      4'h4:    cnd = ~cc[2];
      4'h5:    cnd = ~(cc[1] ^ cc[0]);
      4'h6:    cnd = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cnd = 1'b0;
    endcase
    if (e_q.icode != I_RRMOVQ && e_q.icode != I_JXX) cnd = 1'b0;
    set_cc = (e_q.icode == I_OPQ) && (e_q.stat == S_AOK) && !bus.M_stall_i;
    m_d.stat  = e_q.stat;
    m_d.icode = e_q.icode;
    m_d.cnd   = cnd;
    m_d.val_e = val_e;
    m_d.val_a = e_q.val_a;
    m_d.dst_e = (e_q.icode == I_RRMOVQ && !cnd) ? R_NONE : e_q.dst_e;
    m_d.dst_m = e_q.dst_m;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       cc <= 3'b100;
    else if (set_cc) cc <= {(val_e == 64'h0), val_e[63], of_n};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)               m_q <= M_NOP;
    else if (bus.M_stall_i)  m_q <= m_q;
    else if (bus.M_bubble_i) m_q <= M_NOP;
    else                     m_q <= m_d;
  end

  assign bus.F_predPC_o = f_pred_pc;
  assign bus.M_stat_o   = m_q.stat;
  assign bus.M_icode_o  = m_q.icode;
  assign bus.M_cnd_o    = m_q.cnd;
  assign bus.M_valE_o   = m_q.val_e;
  assign bus.M_valA_o   = m_q.val_a;
  assign bus.M_dstE_o   = m_q.dst_e;
  assign bus.M_dstM_o   = m_q.dst_m;
  assign bus.cc_o       = cc;
endmodule

// File: tb/tb_y86_pred_decode_execute.sv
// Directed bench for y86_pred_decode_execute: hand-computed vectors through decode/execute into the M register.
module tb_y86_pred_decode_execute;
  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  y86_pred_decode_execute_if bus ();

  y86_pred_decode_execute #(.RESET_PC(64'h0)) dut (
    .clk_i (clk_sys),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_nop;
    bus.d_stat_i  = 3'h1;
    bus.d_icode_i = 4'h1;
    bus.d_ifun_i  = 4'h0;
    bus.d_rA_i    = 4'hF;
    bus.d_rB_i    = 4'hF;
    bus.d_valC_i  = 64'h0;
    bus.d_valP_i  = 64'h0;
  endtask

  task automatic set_dec(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    bus.d_stat_i  = 3'h1;
    bus.d_icode_i = ic;
    bus.d_ifun_i  = fn;
    bus.d_rA_i    = ra;
    bus.d_rB_i    = rb;
    bus.d_valC_i  = vc;
    bus.d_valP_i  = vp;
  endtask

  // decode for one edge, then drain one edge so the result sits in M
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    set_dec(ic, fn, ra, rb, vc, vp);
    tick;
    set_nop;
    tick;
  endtask

  task automatic wr(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    bus.W_dstE_i = de;
    bus.W_valE_i = ve;
    bus.W_dstM_i = dm;
    bus.W_valM_i = vm;
    tick;
    bus.W_dstE_i = 4'hF;
    bus.W_dstM_i = 4'hF;
  endtask

  initial begin
    bus.F_stall_i = 0; bus.F_bubble_i = 0;
    bus.E_stall_i = 0; bus.E_bubble_i = 0;
    bus.M_stall_i = 0; bus.M_bubble_i = 0;
    bus.f_predPC_i = 64'h40;
    bus.W_dstE_i = 4'hF; bus.W_dstM_i = 4'hF;
    bus.W_valE_i = 64'h0; bus.W_valM_i = 64'h0;
    set_nop;

    tick; tick;
    check_eq("rst_predpc", bus.F_predPC_o, 64'h0);
    check_eq("rst_icode", {60'h0, bus.M_icode_o}, 64'h1);
    check_eq("rst_dste", {60'h0, bus.M_dstE_o}, 64'hF);
    check_eq("rst_stat", {61'h0, bus.M_stat_o}, 64'h1);
    check_eq("rst_cc", {61'h0, bus.cc_o}, 64'h4);
    rst = 1'b0;

    wr(4'h2, 64'd5, 4'h3, 64'd7);
    issue(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    check_eq("add_vale", bus.M_valE_o, 64'd12);
    check_eq("add_dste", {60'h0, bus.M_dstE_o}, 64'h3);
    check_eq("add_icode", {60'h0, bus.M_icode_o}, 64'h6);
    check_eq("add_cc", {61'h0, bus.cc_o}, 64'h0);

    issue(4'h6, 4'h1, 4'h2, 4'h2, 64'h0, 64'h0);
    check_eq("sub_vale", bus.M_valE_o, 64'h0);
    check_eq("sub_cc", {61'h0, bus.cc_o}, 64'h4);
    issue(4'h2, 4'h3, 4'h2, 4'h6, 64'h0, 64'h0);
    check_eq("cmove_cnd", {63'h0, bus.M_cnd_o}, 64'h1);
    check_eq("cmove_dste", {60'h0, bus.M_dstE_o}, 64'h6);
    check_eq("cmove_vale", bus.M_valE_o, 64'd5);
    issue(4'h2, 4'h4, 4'h2, 4'h6, 64'h0, 64'h0);
    check_eq("cmovne_cnd", {63'h0, bus.M_cnd_o}, 64'h0);
    check_eq("cmovne_dste", {60'h0, bus.M_dstE_o}, 64'hF);

    wr(4'h4, 64'h100, 4'hF, 64'h0);
    issue(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h0);
    check_eq("push_vale", bus.M_valE_o, 64'hF8);
    check_eq("push_vala", bus.M_valA_o, 64'd5);
    check_eq("push_dste", {60'h0, bus.M_dstE_o}, 64'h4);
    issue(4'hB, 4'h0, 4'h1, 4'hF, 64'h0, 64'h0);
    check_eq("pop_vale", bus.M_valE_o, 64'h108);
    check_eq("pop_dstm", {60'h0, bus.M_dstM_o}, 64'h1);
    check_eq("pop_dste", {60'h0, bus.M_dstE_o}, 64'h4);

    issue(4'h7, 4'h0, 4'hF, 4'hF, 64'h0, 64'h77);
    check_eq("jmp_vala", bus.M_valA_o, 64'h77);
    check_eq("jmp_cnd", {63'h0, bus.M_cnd_o}, 64'h1);
    issue(4'hC, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    check_eq("undef_icode", {60'h0, bus.M_icode_o}, 64'hC);
    check_eq("undef_dste", {60'h0, bus.M_dstE_o}, 64'hF);
    check_eq("undef_dstm", {60'h0, bus.M_dstM_o}, 64'hF);

    wr(4'h7, 64'd1, 4'h7, 64'd2);
    issue(4'h2, 4'h0, 4'h7, 4'h8, 64'h0, 64'h0);
    check_eq("dstm_wins", bus.M_valE_o, 64'd2);

    wr(4'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 64'd1);
    issue(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    check_eq("ovf_vale", bus.M_valE_o, 64'h8000_0000_0000_0000);
    check_eq("ovf_cc", {61'h0, bus.cc_o}, 64'h3);

    bus.f_predPC_i = 64'h100; tick;
    check_eq("f_load", bus.F_predPC_o, 64'h100);
    bus.F_stall_i = 1; bus.f_predPC_i = 64'h200; tick;
    check_eq("f_stall", bus.F_predPC_o, 64'h100);
    bus.F_stall_i = 0; bus.F_bubble_i = 1; tick;
    check_eq("f_bubble", bus.F_predPC_o, 64'h0);
    bus.F_bubble_i = 0; tick;
    check_eq("f_reload", bus.F_predPC_o, 64'h200);

    set_dec(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    bus.E_bubble_i = 1; tick;
    bus.E_bubble_i = 0; set_nop; tick;
    check_eq("e_bubble_icode", {60'h0, bus.M_icode_o}, 64'h1);
    check_eq("e_bubble_cc", {61'h0, bus.cc_o}, 64'h3);

    set_dec(4'h3, 4'h0, 4'hF, 4'h5, 64'h55, 64'h0); tick;
    set_dec(4'h6, 4'h1, 4'h2, 4'h2, 64'h0, 64'h0); tick;
    bus.M_stall_i = 1; set_nop; tick;
    check_eq("m_stall_icode", {60'h0, bus.M_icode_o}, 64'h3);
    check_eq("m_stall_vale", bus.M_valE_o, 64'h55);
    check_eq("m_stall_dste", {60'h0, bus.M_dstE_o}, 64'h5);
    check_eq("m_stall_cc", {61'h0, bus.cc_o}, 64'h3);
    bus.M_stall_i = 0; tick;

    set_dec(4'h3, 4'h0, 4'hF, 4'h5, 64'h66, 64'h0); tick;
    bus.E_stall_i = 1; set_dec(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0); tick; tick;
    check_eq("e_stall_icode", {60'h0, bus.M_icode_o}, 64'h3);
    check_eq("e_stall_cc", {61'h0, bus.cc_o}, 64'h3);
    bus.E_stall_i = 0; set_nop; bus.M_bubble_i = 1; tick;
    check_eq("m_bubble_icode", {60'h0, bus.M_icode_o}, 64'h1);
    bus.M_bubble_i = 0; tick; tick;

    set_dec(4'h2, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    bus.W_dstE_i = 4'h2; bus.W_valE_i = 64'd9;
    tick;
    bus.W_dstE_i = 4'hF; set_nop; tick;
`ifdef WB_BYPASS_EN
    check_eq("bypass_vala", bus.M_valA_o, 64'd9);
`else
    check_eq("bypass_vala", bus.M_valA_o, 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
